// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants, FSM state encoding and the one-hot to index encoder
// used by the round-robin grant arbiter.
package rr_grant_encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_encoder_pick.sv
// Combinational rotate-priority pick: first set request bit scanning from ptr
// upward with wrap-around.
module rr_pick4
  import rr_grant_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    any    = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Index arithmetic is IDX_W wide, so the scan wraps modulo NUM_REQ.
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 4 requesters with held grants, binary grant index
// and forced release after MAX_HOLD cycles.
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               hold_expired;
  logic               release_now;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD));
  assign release_now  = done || !req[gnt_idx_q] || hold_expired;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_BUSY;
          gnt_d     = NUM_REQ'(1) << winner;
          gnt_idx_d = onehot_to_idx(gnt_d);
          cnt_d     = CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = gnt_idx_q + 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Pulse lives in the final held cycle; a concurrent done or reset suppresses it.
  assign timeout   = !rst && (state_q == ST_BUSY) && hold_expired && !done;
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: an owner/pointer model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rr_grant_encoder;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_grant_encoder #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how long, and where the next scan starts.
  int  m_owner = -1;
  int  m_ptr   = 0;
  int  m_hold  = 0;
  int  m_last  = 0;
  bit  m_ok    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_ok = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_last = c; m_hold = 1;
        end
      end
    end else if (done || !req[m_owner] || m_hold == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_hold = 0;
    end else begin
      m_hold++;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("model_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      check("model_idx", int'(gnt_idx), m_last);
      check("model_timeout", int'(timeout),
            (m_owner >= 0 && m_hold == MAX_HOLD && !done && !rst) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n, to_cnt, to_at, guard;

    rst = 1'b1; req = 4'b1111; done = 1'b0;
    repeat (3) begin
      tick();
      check("rst_gnt", int'(gnt), 0);
      check("rst_valid", int'(gnt_valid), 0);
      check("rst_idx", int'(gnt_idx), 0);
      check("rst_timeout", int'(timeout), 0);
    end
    rst = 1'b0; req = 4'b0000;
    tick();

    // Single requester, then ptr lands on 3.
    req = 4'b0100;
    tick();
    check("single_gnt", int'(gnt), 4);
    check("single_idx", int'(gnt_idx), 2);
    req = 4'b0110;
    tick();
    check("single_hold_gnt", int'(gnt), 4);
    done = 1'b1;
    tick();
    check("single_rel_gnt", int'(gnt), 0);
    check("single_rel_idx", int'(gnt_idx), 2);
    done = 1'b0; req = 4'b0000;
    tick();

    // Wrap from ptr=3 to idx 0, then idx 1.
    req = 4'b0011;
    tick();
    check("wrap_idx", int'(gnt_idx), 0);
    check("wrap_gnt", int'(gnt), 1);
    done = 1'b1;
    tick();
    check("wrap_dead", int'(gnt_valid), 0);
    done = 1'b0;
    tick();
    check("skip_idx", int'(gnt_idx), 1);
    check("skip_gnt", int'(gnt), 2);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();

    // Round robin from ptr=0 with everyone requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_idx", int'(gnt_idx), exp_seq[i]);
      check("rr_gnt", int'(gnt), 1 << exp_seq[i]);
      done = 1'b1;
      tick();
      check("rr_dead", int'(gnt_valid), 0);
      done = 1'b0;
    end
    req = 4'b0000;
    tick();

    // Timeout: ptr=1, sole requester 0 holds until forced off.
    req = 4'b0001;
    tick();
    n = 0; to_cnt = 0; to_at = -1; guard = 0;
    while (gnt_valid && guard < 40) begin
      n++;
      if (timeout) begin to_cnt++; to_at = n; end
      guard++;
      tick();
    end
    req = 4'b0000;
    check("to_hold_cycles", n, 16);
    check("to_pulses", to_cnt, 1);
    check("to_cycle", to_at, 16);
    check("to_rel_gnt", int'(gnt), 0);
    req = 4'b0011;
    tick();
    check("to_next_idx", int'(gnt_idx), 1);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();

    // done at the final held cycle suppresses timeout.
    req = 4'b0001;
    tick();
    repeat (15) tick();
    check("to_edge_valid", int'(gnt_valid), 1);
    done = 1'b1;
    #1;
    check("to_done_suppress", int'(timeout), 0);
    tick();
    check("to_done_rel", int'(gnt_valid), 0);
    done = 1'b0; req = 4'b0000;
    tick();

    // Withdrawal release; other req bits ignored while busy.
    req = 4'b0100;
    tick();
    check("wd_idx", int'(gnt_idx), 2);
    req = 4'b1111;
    tick();
    check("wd_stable", int'(gnt), 4);
    req = 4'b0000; done = 1'b1;
    tick();
    check("wd_rel", int'(gnt_valid), 0);
    done = 1'b1;
    tick();
    check("idle_done", int'(gnt_valid), 0);
    done = 1'b0;

    // Reset mid-grant.
    req = 4'b1000;
    tick();
    check("mid_gnt", int'(gnt), 8);
    rst = 1'b1;
    #1;
    check("mid_rst_timeout", int'(timeout), 0);
    tick();
    check("mid_rst_gnt", int'(gnt), 0);
    check("mid_rst_idx", int'(gnt_idx), 0);
    rst = 1'b0; req = 4'b1001;
    tick();
    check("post_rst_idx", int'(gnt_idx), 0);
    check("post_rst_gnt", int'(gnt), 1);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
